// File: rtl/dram_fifo_pkg.sv
// Shared defaults and handshake type for the LUTRAM-backed FIFO and its storage.
package dram_fifo_pkg;

    localparam int unsigned FIFO_WIDTH_DEF = 32;
    localparam int unsigned FIFO_DEPTH_DEF = 16;

    typedef struct packed {
        logic push;
        logic pop;
    } xfer_t;

endpackage

// File: rtl/dram_fifo_dpram.sv
// Dual-port distributed RAM: port A synchronous write with async readback, port B async read.
// Contents are not reset; reads are combinational (zero latency), no backpressure.
module DistributedRAM
    import dram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             a_we_i,
    input  logic [AW-1:0]    a_addr_i,
    input  logic [WIDTH-1:0] a_wdata_i,
    output logic [WIDTH-1:0] a_rdata_o,
    input  logic [AW-1:0]    b_addr_i,
    output logic [WIDTH-1:0] b_rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
    end

    assign a_rdata_o = mem_q[a_addr_i];
    assign b_rdata_o = mem_q[b_addr_i];

endmodule

// File: rtl/dram_fifo.sv
// Synchronous FIFO on distributed RAM; head is read combinationally, push visible after 1 cycle.
// in_ready = !full only (a pop never frees a slot in the same cycle); flush drops everything.
module dram_fifo
    import dram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] head_q, head_d;
    logic [ADDR_WIDTH:0] tail_q, tail_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                empty, full;
    xfer_t               xfer;
    logic [WIDTH-1:0]    unused_a_rdata;

    // Extra MSB on each pointer is the wrap bit that separates full from empty.
    assign empty = (head_q == tail_q);
    assign full  = (head_q[ADDR_WIDTH-1:0] == tail_q[ADDR_WIDTH-1:0]) &&
                   (head_q[ADDR_WIDTH] != tail_q[ADDR_WIDTH]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;
    assign xfer      = '{push: in_valid & in_ready, pop: out_valid & out_ready};

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (xfer.push) tail_d = tail_q + PTR_ONE;
            if (xfer.pop)  head_d = head_q + PTR_ONE;
            case ({xfer.push, xfer.pop})
                2'b10:   count_d = count_q + PTR_ONE;
                2'b01:   count_d = count_q - PTR_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    DistributedRAM #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .a_we_i    (xfer.push & !flush),
        .a_addr_i  (tail_q[ADDR_WIDTH-1:0]),
        .a_wdata_i (in_data),
        .a_rdata_o (unused_a_rdata),
        .b_addr_i  (head_q[ADDR_WIDTH-1:0]),
        .b_rdata_o (out_data)
    );

endmodule

// File: tb/tb_dram_fifo.sv
// Randomized and directed stimulus against a queue-based reference of the FIFO.
module tb_dram_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic              clk;
    logic              resetn;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [4:0]        count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] ref_q [$];

    dram_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        check_eq("count", 32'(count), 32'(ref_q.size()));
        check_eq("out_valid", 32'(out_valid), 32'(ref_q.size() != 0));
        check_eq("in_ready", 32'(in_ready), 32'(ref_q.size() != DEPTH));
        if (ref_q.size() != 0)
            check_eq("out_data", out_data, ref_q[0]);
    endtask

    // Called at a falling edge: check current state, drive inputs, advance the model.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
        bit do_push, do_pop;
        check_state();
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        if (fl) begin
            ref_q.delete();
        end else begin
            do_push = iv && (ref_q.size() < DEPTH);
            do_pop  = ordy && (ref_q.size() > 0);
            if (do_pop)  void'(ref_q.pop_front());
            if (do_push) ref_q.push_back(d);
        end
        @(negedge clk);
    endtask

    initial begin
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_count", 32'(count), 32'd0);
        resetn = 1'b1;

        repeat (10) cycle(1'b0, '0, 1'b0, 1'b0);

        // Fill to full, one rejected push, then drain.
        for (int i = 1; i <= 16; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Steady push+pop at occupancy 3; pointers wrap twice.
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, $urandom, 1'b1, 1'b0);

        // Full with simultaneous push and pop: only the pop lands.
        for (int i = 0; i < 13; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Flush from occupancy 5, then a single push shows up a cycle later.
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b1, 32'h1234, 1'b1, 1'b1);
        cycle(1'b1, 32'hAB, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-burst at occupancy 7.
        for (int i = 0; i < 7; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        check_eq("pre_rst_count", 32'(count), 32'd7);
        in_valid = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        check_eq("arst_count", 32'(count), 32'd0);
        ref_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 40) == 0));
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check_state();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
